// File: rtl/multicycle_control.sv
// Multi-cycle MIPS controller: a Moore FSM that sequences the shared datapath
// (PC, memory, register file, ALU) across fetch, decode, execute, memory and writeback.
module multicycle_control #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [0:5] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [0:1] ALUSrcB,
  output logic [0:1] ALUOp,
  output logic [0:2] ALUOpImmediate,
  output logic [0:1] PCSource,
  output logic [0:3] state,
  output logic       instr_done,
  output logic       illegal
);

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SUBI  = 6'b001111;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTYPE  = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11,
    S_TRAP   = 4'd15
  } state_e;

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            illegal_q, illegal_d;
  logic [OP_W-1:0] opcode_c;
  state_e          dec_next_c;
  logic            unknown_c;

  assign opcode_c = Opcode;

  // ALU immediate function select, taken from the opcode latched in DECODE
  function automatic logic [2:0] imm_sel(input logic [OP_W-1:0] op);
    case (op)
      OP_ADDI: imm_sel = 3'b000;
      OP_SUBI: imm_sel = 3'b001;
      OP_ANDI: imm_sel = 3'b010;
      OP_ORI:  imm_sel = 3'b011;
      OP_SLTI: imm_sel = 3'b100;
      default: imm_sel = 3'b000;
    endcase
  endfunction

  // Opcode decode, only consumed in DECODE
  always_comb begin
    dec_next_c = S_FETCH;
    unknown_c  = 1'b0;
    case (opcode_c)
      OP_RTYPE:                                 dec_next_c = S_RTYPE;
      OP_LW, OP_SW:                             dec_next_c = S_MEMADR;
      OP_BEQ:                                   dec_next_c = S_BEQ;
      OP_J:                                     dec_next_c = S_JUMP;
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI: dec_next_c = S_IMMEX;
      default: begin
        unknown_c  = 1'b1;
        dec_next_c = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        state_d   = dec_next_c;
        op_d      = opcode_c;
        illegal_d = illegal_q | unknown_c;
      end
      S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPE:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_IMMEX:  state_d = S_IMMWB;
      S_IMMWB:  state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode; everything is held low while reset is asserted
  always_comb begin
    PCWrite        = 1'b0;
    PCWriteCond    = 1'b0;
    IorD           = 1'b0;
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    IRWrite        = 1'b0;
    RegDst         = 1'b0;
    MemToReg       = 1'b0;
    RegWrite       = 1'b0;
    ALUSrcA        = 1'b0;
    ALUSrcB        = 2'b00;
    ALUOp          = 2'b00;
    ALUOpImmediate = 3'b000;
    PCSource       = 2'b00;
    instr_done     = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB    = 2'b11;
          instr_done = unknown_c & ~TRAP_ON_ILLEGAL;
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite   = 1'b1;
          MemToReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_RTYPE: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_ALUWB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        S_BEQ: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
        S_IMMEX: begin
          ALUSrcA        = 1'b1;
          ALUSrcB        = 2'b10;
          ALUOp          = 2'b11;
          ALUOpImmediate = imm_sel(op_q);
        end
        S_IMMWB: begin
          RegWrite       = 1'b1;
          ALUOp          = 2'b11;
          ALUOpImmediate = imm_sel(op_q);
          instr_done     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state   = reset ? 4'd0 : 4'(state_q);
  assign illegal = illegal_q & ~reset;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM controller that sequences the shared MIPS datapath (pc, InstructionMemory, reg_file, alu, sign_extend, operand muxes) over multiple cycles per instruction.
- Replaces the single-cycle `control` decode: one ALU and one memory port are reused across fetch, execute and memory phases.
- Drives all mux selects and write enables, and feeds ALUOp/ALUOpImmediate to `alu_control`.
- Waits on a memory-ready handshake in the fetch and memory phases.

Parameters:
- TRAP_ON_ILLEGAL, 1, 1 = an unknown opcode parks the FSM in TRAP until reset; 0 = an unknown opcode is treated as a NOP (returns to FETCH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- Opcode  input  [0:5]  instruction[0:5] from the instruction register; sampled in DECODE only.
- mem_ready  input  1  memory completes the current read/write this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load if ALU zero (beq).
- IorD  output  1  0 = PC addresses memory; 1 = ALU result addresses memory.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register load.
- RegDst  output  1  1 = write register instruction[16:20]; 0 = instruction[11:15].
- MemToReg  output  1  1 = write data from memory data register.
- RegWrite  output  1  reg_file write enable.
- ALUSrcA  output  1  0 = PC; 1 = readdata1.
- ALUSrcB  output  [0:1]  00 = readdata2; 01 = constant 4; 10 = sign_out; 11 = sign_out<<2.
- ALUOp  output  [0:1]  00 = add; 01 = sub; 10 = funct field; 11 = use ALUOpImmediate.
- ALUOpImmediate  output  [0:2]  000 = addi; 001 = subi; 010 = andi; 011 = ori; 100 = slti.
- PCSource  output  [0:1]  00 = ALU; 01 = ALUOut; 10 = jump target.
- state  output  [0:3]  current state, for debug.
- instr_done  output  1  one-cycle pulse in the final cycle of each instruction.
- illegal  output  1  sticky flag: an unknown opcode was decoded.

Behaviour:
- Reset:
  - Synchronous; state <= FETCH and illegal <= 0.
  - While reset = 1, all outputs are forced to 0.
  - Reset asserted mid-instruction aborts it; no write enable is asserted in that cycle.
- Outputs are decoded from state only. Exception: PCWrite and IRWrite in FETCH, which are gated by mem_ready.
- Any output not listed for a state is 0.
- States and transitions:
  - 0 FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00; IRWrite = PCWrite = mem_ready. Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
  - 1 DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target precompute). Next state by Opcode:
    - 000000 -> RTYPE
    - 100011 / 101011 (lw / sw) -> MEMADR
    - 000100 -> BEQ
    - 000010 -> JUMP
    - 001000 / 001111 / 001100 / 001101 / 001010 -> IMMEX
    - any other opcode -> illegal <= 1; TRAP if TRAP_ON_ILLEGAL = 1, else FETCH with an instr_done pulse.
  - 2 MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. lw -> MEMRD; sw -> MEMWR. The opcode is latched in DECODE, not re-read.
  - 3 MEMRD: MemRead = 1, IorD = 1. Waits for mem_ready, then goes to MEMWB.
  - 4 MEMWB: RegWrite = 1, MemToReg = 1, RegDst = 0, instr_done = 1 -> FETCH.
  - 5 MEMWR: MemWrite = 1, IorD = 1. When mem_ready = 1: instr_done = 1 -> FETCH. MemWrite stays high while waiting.
  - 6 RTYPE: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10 -> ALUWB.
  - 7 ALUWB: RegWrite = 1, RegDst = 1, MemToReg = 0, instr_done = 1 -> FETCH.
  - 8 BEQ: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01, instr_done = 1 -> FETCH.
  - 9 JUMP: PCWrite = 1, PCSource = 10, instr_done = 1 -> FETCH.
  - 10 IMMEX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 11; ALUOpImmediate per the encoding in Ports, from the latched opcode -> IMMWB.
  - 11 IMMWB: RegWrite = 1, RegDst = 0, MemToReg = 0, instr_done = 1 -> FETCH. ALUOp and ALUOpImmediate are held from IMMEX.
  - 15 TRAP: all strobes 0; stays in TRAP until reset.
  - Codes 12–14 are unused; if reached, the next state is FETCH.
- Latency with mem_ready tied to 1:
  - R-type 4 cycles; I-type ALU 4; lw 5; sw 4; beq 3; j 3.
  - Each mem_ready = 0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- At most one of MemRead and MemWrite is asserted in any cycle.
- RegWrite is asserted only in the writeback states.
- instr_done pulses exactly once per retired instruction.

Test Plan:
- Reset held 2 cycles, then addi (001000) with mem_ready = 1:
  - Required: states 0, 1, 10, 11.
  - In state 10: ALUOp = 11, ALUOpImmediate = 000.
  - In state 11: RegWrite = 1, RegDst = 0, and instr_done pulses there.
- Each of subi, andi, ori, slti:
  - Required: ALUOpImmediate = 001, 010, 011, 100 respectively in IMMEX.
  - Total latency 4 cycles.
- lw with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD:
  - Required: IRWrite and PCWrite stay 0 until mem_ready = 1.
  - Total latency 10 cycles; MemToReg = 1 in MEMWB.
- sw followed by beq:
  - sw: MemWrite = 1 and IorD = 1 in state 5; retires in 4 cycles.
  - beq: PCWriteCond = 1, PCSource = 01, ALUOp = 01; retires in 3 cycles.
- Opcode 111111:
  - TRAP_ON_ILLEGAL = 1: illegal = 1, state = 15 and held; a later reset clears both.
  - TRAP_ON_ILLEGAL = 0: illegal = 1, instr_done pulses, and the next instruction fetches normally.
- Reset asserted in MEMWR with mem_ready = 0:
  - Required: MemWrite = 0 in that cycle, and the next state is FETCH.
